// File: rtl/fei4_rx_fifo_writer_if.sv
// Decoded-byte input stream and CDC FIFO write port of the FE-I4 record writer.
interface fei4_rx_fifo_writer_if;
  logic        din_valid;
  logic        din_k;
  logic [7:0]  din;
  logic        wfull;
  logic [31:0] wdata;
  logic        winc;

  // master: the record writer (consumes bytes, drives FIFO writes)
  modport master (
    input  din_valid, din_k, din, wfull,
    output wdata, winc
  );

  // slave: the environment (decoder feeding bytes, FIFO accepting words)
  modport slave (
    output din_valid, din_k, din, wfull,
    input  wdata, winc
  );
endinterface

// File: rtl/fei4_rx_fifo_writer.sv
// Frames decoded FE-I4 bytes (SOF/EOF K-codes) into 24-bit records and writes
// tagged 32-bit words into a CDC FIFO, keeping frame/lost/error counters.
module fei4_rx_fifo_writer #(
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic                         wclk,
  input  logic                         rrst,
  input  logic                         enable,
  fei4_rx_fifo_writer_if.master        bus,
  output logic                         in_frame,
  output logic [15:0]                  frame_cnt,
  output logic [7:0]                   lost_cnt,
  output logic [7:0]                   err_cnt
);

  localparam logic [7:0] K_SOF  = 8'hFC;
  localparam logic [7:0] K_EOF  = 8'hBC;
  localparam logic [7:0] K_IDLE = 8'h3C;

  typedef enum logic [1:0] {IDLE, B0, B1, B2} state_t;

  state_t      state, state_n;
  logic [15:0] rec, rec_n;          // record bytes 0 and 1; byte 2 goes straight to the word
  logic        first_flag, first_n;
  logic        push_pending, push_n;
  logic [31:0] wdata_q, word_n;
  logic        err_inc, frame_inc;

  logic is_sof, is_eof, is_idle;
  assign is_sof  = bus.din_k && (bus.din == K_SOF);
  assign is_eof  = bus.din_k && (bus.din == K_EOF);
  assign is_idle = bus.din_k && (bus.din == K_IDLE);

  assign in_frame  = (state != IDLE);
  assign bus.wdata = wdata_q;
  assign bus.winc  = push_pending && !bus.wfull && enable;

  // Next-state, record assembly and push/counter requests for the current byte.
  // Truncated records carry ferr only; first is reported on complete records.
  always_comb begin
    state_n   = state;
    rec_n     = rec;
    first_n   = first_flag;
    push_n    = 1'b0;
    word_n    = wdata_q;
    err_inc   = 1'b0;
    frame_inc = 1'b0;
    if (bus.din_valid) begin
      if (state == IDLE) begin
        if (is_sof) begin
          state_n = B0;
          first_n = 1'b1;
        end else if (!is_idle) begin
          err_inc = 1'b1;
        end
      end else if (bus.din_k) begin
        if (is_sof) begin
          err_inc = 1'b1;
          if (state != B0) begin
            push_n = 1'b1;
            word_n = {CHANNEL, 1'b0, 1'b1, 2'b00, rec, 8'h00};
          end
          state_n = B0;
          first_n = 1'b1;
        end else if (is_eof) begin
          frame_inc = 1'b1;
          state_n   = IDLE;
          first_n   = 1'b0;
          if (state != B0) begin
            err_inc = 1'b1;
            push_n  = 1'b1;
            word_n  = {CHANNEL, 1'b0, 1'b1, 2'b00, rec, 8'h00};
          end
        end else if (!is_idle) begin
          err_inc = 1'b1;
        end
      end else begin
        case (state)
          B0: begin
            rec_n   = {bus.din, 8'h00};
            state_n = B1;
          end
          B1: begin
            rec_n   = {rec[15:8], bus.din};
            state_n = B2;
          end
          default: begin
            push_n  = 1'b1;
            word_n  = {CHANNEL, first_flag, 1'b0, 2'b00, rec, bus.din};
            first_n = 1'b0;
            state_n = B0;
          end
        endcase
      end
    end
  end

  // State, output word and counter registers.
  always_ff @(posedge wclk) begin
    if (rrst) begin
      state        <= IDLE;
      rec          <= '0;
      first_flag   <= 1'b0;
      push_pending <= 1'b0;
      wdata_q      <= '0;
      frame_cnt    <= '0;
      lost_cnt     <= '0;
      err_cnt      <= '0;
    end else if (!enable) begin
      state        <= IDLE;
      first_flag   <= 1'b0;
      push_pending <= 1'b0;
    end else begin
      state        <= state_n;
      rec          <= rec_n;
      first_flag   <= first_n;
      push_pending <= push_n;
      if (push_n)
        wdata_q <= word_n;
      if (frame_inc)
        frame_cnt <= frame_cnt + 16'd1;
      if (err_inc && (err_cnt != '1))
        err_cnt <= err_cnt + 8'd1;
      if (push_pending && bus.wfull && (lost_cnt != '1))
        lost_cnt <= lost_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_fei4_rx_fifo_writer.sv
// Scoreboard bench for fei4_rx_fifo_writer: directed byte streams push expected
// FIFO words into a queue; a monitor pops and compares on every winc.
module tb_fei4_rx_fifo_writer;
  logic        wclk = 1'b0;
  logic        rrst = 1'b1;
  logic        enable = 1'b1;
  logic        in_frame;
  logic [15:0] frame_cnt;
  logic [7:0]  lost_cnt;
  logic [7:0]  err_cnt;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  localparam logic [7:0] SOF = 8'hFC;
  localparam logic [7:0] EOF = 8'hBC;

  fei4_rx_fifo_writer_if bus();

  fei4_rx_fifo_writer #(.CHANNEL(4'd0)) dut (
    .wclk(wclk), .rrst(rrst), .enable(enable), .bus(bus),
    .in_frame(in_frame), .frame_cnt(frame_cnt),
    .lost_cnt(lost_cnt), .err_cnt(err_cnt)
  );

  always #5 wclk = ~wclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic send(input logic k, input logic [7:0] d);
    bus.din_valid = 1'b1;
    bus.din_k     = k;
    bus.din       = d;
    @(posedge wclk); #1;
    bus.din_valid = 1'b0;
    bus.din_k     = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge wclk); #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".wdata"}, bus.wdata, 32'h0);
    check({tag, ".winc"}, {31'h0, bus.winc}, 32'h0);
    check({tag, ".in_frame"}, {31'h0, in_frame}, 32'h0);
    check({tag, ".frame_cnt"}, {16'h0, frame_cnt}, 32'h0);
    check({tag, ".lost_cnt"}, {24'h0, lost_cnt}, 32'h0);
    check({tag, ".err_cnt"}, {24'h0, err_cnt}, 32'h0);
  endtask

  // Monitor: every FIFO write must match the oldest expected word.
  always @(negedge wclk) begin
    if (!rrst && bus.winc) begin
      checks++;
      if (bus.wfull) begin
        failures++;
        $display("FAIL winc_while_full: winc=1 wfull=1 required winc=0");
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_winc: wdata=0x%08h with no word expected", bus.wdata);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (bus.wdata !== e) begin
          failures++;
          $display("FAIL wdata: got 0x%08h expected 0x%08h", bus.wdata, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.din_valid = 1'b0;
    bus.din_k     = 1'b0;
    bus.din       = 8'h00;
    bus.wfull     = 1'b0;
    rrst = 1'b1;
    idle(3);
    rrst = 1'b0;
    check_all_zero("reset");

    // Basic frame, one complete record
    exp_q.push_back(32'h0811_2233);
    send(1, SOF); send(0, 8'h11); send(0, 8'h22); send(0, 8'h33);
    check("mid_frame.in_frame", {31'h0, in_frame}, 32'h1);
    send(1, EOF);
    idle(3);
    check("basic.frame_cnt", {16'h0, frame_cnt}, 32'd1);
    check("basic.err_cnt", {24'h0, err_cnt}, 32'd0);
    check("basic.in_frame", {31'h0, in_frame}, 32'h0);

    // Two records: first flag only on the first
    exp_q.push_back(32'h0801_0203);
    exp_q.push_back(32'h0004_0506);
    send(1, SOF);
    for (int unsigned i = 1; i <= 6; i++) send(0, 8'(i));
    send(1, EOF);
    idle(3);
    check("two_rec.err_cnt", {24'h0, err_cnt}, 32'd0);
    check("two_rec.frame_cnt", {16'h0, frame_cnt}, 32'd2);

    // Truncated record at EOF
    exp_q.push_back(32'h04AA_0000);
    send(1, SOF); send(0, 8'hAA); send(1, EOF);
    idle(3);
    check("trunc.err_cnt", {24'h0, err_cnt}, 32'd1);
    check("trunc.frame_cnt", {16'h0, frame_cnt}, 32'd3);

    // In-frame idle K ignored, unknown K counted, SOF restart pushes partial
    exp_q.push_back(32'h0412_3400);
    exp_q.push_back(32'h0856_789A);
    send(1, SOF); send(0, 8'h12); send(1, 8'h3C); send(0, 8'h34); send(1, 8'h1C);
    check("unk_k.in_frame", {31'h0, in_frame}, 32'h1);
    send(1, SOF); send(0, 8'h56); send(0, 8'h78); send(0, 8'h9A); send(1, EOF);
    idle(3);
    check("restart.err_cnt", {24'h0, err_cnt}, 32'd3);
    check("restart.frame_cnt", {16'h0, frame_cnt}, 32'd4);

    // enable drop: pending push discarded silently, framing forced idle
    send(1, SOF); send(0, 8'h01); send(0, 8'h02); send(0, 8'h03);
    enable = 1'b0;
    idle(2);
    enable = 1'b1;
    check("enable.in_frame", {31'h0, in_frame}, 32'h0);
    check("enable.lost_cnt", {24'h0, lost_cnt}, 32'd0);
    check("enable.frame_cnt", {16'h0, frame_cnt}, 32'd4);
    send(0, 8'h04);
    check("enable.stray_err", {24'h0, err_cnt}, 32'd4);

    // FIFO full for 300 records: no writes, lost saturates
    bus.wfull = 1'b1;
    send(1, SOF);
    for (int unsigned i = 0; i < 900; i++) send(0, 8'(i));
    send(1, EOF);
    bus.wfull = 1'b0;
    idle(3);
    check("full.lost_cnt", {24'h0, lost_cnt}, 32'd255);
    check("full.frame_cnt", {16'h0, frame_cnt}, 32'd5);
    check("full.err_cnt", {24'h0, err_cnt}, 32'd4);

    // Stray bytes in IDLE, then reset mid-frame
    send(0, 8'h55); send(0, 8'h66); send(1, EOF);
    check("stray.err_cnt", {24'h0, err_cnt}, 32'd7);
    send(1, SOF); send(0, 8'h11); send(0, 8'h22);
    rrst = 1'b1;
    idle(1);
    rrst = 1'b0;
    check_all_zero("midreset");
    exp_q.push_back(32'h08A1_B2C3);
    send(1, SOF); send(0, 8'hA1); send(0, 8'hB2); send(0, 8'hC3); send(1, EOF);
    idle(3);
    check("post_reset.frame_cnt", {16'h0, frame_cnt}, 32'd1);
    check("post_reset.err_cnt", {24'h0, err_cnt}, 32'd0);

    idle(4);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
